// File: rtl/postage_stall_pkg.sv
// Shared types and helpers for the postage AXI-Stream stall detector.
package postage_stall_pkg;

  typedef enum logic [1:0] {StIdle, StArmed, StTripped} stall_state_e;

  localparam int unsigned DEFAULT_NUM_CH = 10;
  localparam int unsigned DEFAULT_CNT_W  = 16;
  // Upper bound on channel count accepted by the priority encoder.
  localparam int unsigned MAX_CH         = 64;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowest_index(input logic [MAX_CH-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/postage_stall_counter.sv
// One channel's saturating stall counter and threshold compare.
module postage_stall_counter #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned THRESHOLD = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  output logic block_next,
  output logic block
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] Thr    = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (stall) begin
      cnt_next = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  assign block_next = (cnt_next >= Thr);
  assign block      = (cnt_q >= Thr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

endmodule

// File: rtl/postage_axis_stall_detector.sv
// Per-channel persistent-stall detection feeding the postage deadlock monitor,
// with first-trip capture and a sticky mask for debug readout.
module postage_axis_stall_detector
  import postage_stall_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEFAULT_NUM_CH,
  parameter int unsigned CNT_W     = DEFAULT_CNT_W,
  parameter int unsigned THRESHOLD = 1024,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              inst_idle,
  input  logic [NUM_CH-1:0] axis_tvalid,
  input  logic [NUM_CH-1:0] axis_tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              first_valid,
  output logic [CH_W-1:0]   first_ch,
  output logic [NUM_CH-1:0] sticky_mask,
  output logic              trip_pulse
);

  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] block_next;
  logic [MAX_CH-1:0] block_pad;
  logic [CH_W-1:0]   trip_ch;
  logic              trip_now;
  stall_state_e      state_q;

  assign stall = axis_tvalid & ~axis_tready & {NUM_CH{~inst_idle & enable}};

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    postage_stall_counter #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD)
    ) u_counter (
      .clock      (clock),
      .reset      (reset),
      .stall      (stall[i]),
      .block_next (block_next[i]),
      .block      (axis_block_sigs[i])
    );
  end

  always_comb begin
    block_pad               = '0;
    block_pad[NUM_CH-1:0]   = block_next;
  end

  assign trip_ch  = CH_W'(lowest_index(block_pad));
  assign trip_now = |block_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      first_valid <= 1'b0;
      first_ch    <= '0;
      sticky_mask <= '0;
      trip_pulse  <= 1'b0;
    end else begin
      trip_pulse  <= 1'b0;
      // block_next is all-zero while disabled, so this also covers IDLE.
      sticky_mask <= clear ? block_next : (sticky_mask | block_next);
      if (!enable) begin
        state_q <= StIdle;
        if (clear) begin
          first_valid <= 1'b0;
          first_ch    <= '0;
        end
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StArmed;
            if (clear) begin
              first_valid <= 1'b0;
              first_ch    <= '0;
            end
          end
          StArmed: begin
            if (trip_now) begin
              state_q     <= StTripped;
              first_valid <= 1'b1;
              first_ch    <= trip_ch;
              trip_pulse  <= 1'b1;
            end else if (clear) begin
              first_valid <= 1'b0;
              first_ch    <= '0;
            end
          end
          StTripped: begin
            if (clear) begin
              // A trip coinciding with clear is recaptured rather than lost.
              if (trip_now) begin
                first_valid <= 1'b1;
                first_ch    <= trip_ch;
                trip_pulse  <= 1'b1;
              end else begin
                state_q     <= StArmed;
                first_valid <= 1'b0;
                first_ch    <= '0;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_postage_axis_stall_detector.sv
// Directed bench for the postage AXI-Stream stall detector (THRESHOLD=4,
// plus a CNT_W=4 instance for saturation).
module tb_postage_axis_stall_detector;
  import postage_stall_pkg::*;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       clear;
  logic       inst_idle;
  logic [9:0] tvalid;
  logic [9:0] tready;
  logic [9:0] block;
  logic       first_valid;
  logic [3:0] first_ch;
  logic [9:0] sticky;
  logic       trip_pulse;

  logic       enable_s;
  logic [9:0] tvalid_s;
  logic [9:0] block_s;
  logic       first_valid_s;
  logic [3:0] first_ch_s;
  logic [9:0] sticky_s;
  logic       trip_pulse_s;

  int total;
  int bad;

  postage_axis_stall_detector #(
    .NUM_CH    (10),
    .CNT_W     (16),
    .THRESHOLD (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .clear           (clear),
    .inst_idle       (inst_idle),
    .axis_tvalid     (tvalid),
    .axis_tready     (tready),
    .axis_block_sigs (block),
    .first_valid     (first_valid),
    .first_ch        (first_ch),
    .sticky_mask     (sticky),
    .trip_pulse      (trip_pulse)
  );

  postage_axis_stall_detector #(
    .NUM_CH    (10),
    .CNT_W     (4),
    .THRESHOLD (4)
  ) dut_sat (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable_s),
    .clear           (clear),
    .inst_idle       (inst_idle),
    .axis_tvalid     (tvalid_s),
    .axis_tready     (tready),
    .axis_block_sigs (block_s),
    .first_valid     (first_valid_s),
    .first_ch        (first_ch_s),
    .sticky_mask     (sticky_s),
    .trip_pulse      (trip_pulse_s)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    clear     = 1'b0;
    inst_idle = 1'b0;
    tvalid    = '0;
    tready    = '0;
    enable_s  = 1'b0;
    tvalid_s  = '0;

    #1;
    chk("rst_block", block, 10'h000);
    chk("rst_first_valid", first_valid, 1'b0);
    chk("rst_first_ch", first_ch, 4'd0);
    chk("rst_sticky", sticky, 10'h000);
    chk("rst_pulse", trip_pulse, 1'b0);
    chk("rst_state", dut.state_q, StIdle);
    #12;
    reset = 1'b0;

    // Saturation: CNT_W=4, 40 stall edges on ch0.
    enable_s = 1'b1;
    tvalid_s = 10'h001;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("sat_cnt", dut_sat.gen_ch[0].u_counter.cnt_q, (i + 1 > 15) ? 15 : i + 1);
      chk("sat_block", block_s[0], (i >= 3) ? 1'b1 : 1'b0);
    end
    tvalid_s = '0;
    enable_s = 1'b0;
    tick();
    chk("sat_release", block_s, 10'h000);

    // Test 1: ch3 stalls 4 edges.
    enable = 1'b1;
    tick();
    chk("t1_armed", dut.state_q, StArmed);
    tvalid = 10'h008;
    repeat (3) tick();
    chk("t1_block_pre", block, 10'h000);
    chk("t1_pulse_pre", trip_pulse, 1'b0);
    tick();
    chk("t1_block", block, 10'h008);
    chk("t1_first_ch", first_ch, 4'd3);
    chk("t1_first_valid", first_valid, 1'b1);
    chk("t1_pulse", trip_pulse, 1'b1);
    chk("t1_sticky", sticky, 10'h008);
    chk("t1_state", dut.state_q, StTripped);
    tick();
    chk("t1_pulse_once", trip_pulse, 1'b0);
    chk("t1_block_hold", block, 10'h008);
    tready = 10'h008;
    tick();
    chk("t1_block_fall", block, 10'h000);
    chk("t1_sticky_hold", sticky, 10'h008);

    // Test 2: ch2 stall 3, transfer, stall 3.
    tvalid = '0;
    tready = '0;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    chk("t2_clr_valid", first_valid, 1'b0);
    chk("t2_clr_sticky", sticky, 10'h000);
    chk("t2_clr_state", dut.state_q, StArmed);
    tvalid = 10'h004;
    repeat (3) tick();
    tready = 10'h004;
    tick();
    chk("t2_cnt_reset", dut.gen_ch[2].u_counter.cnt_q, 16'd0);
    tready = '0;
    repeat (3) tick();
    chk("t2_block", block, 10'h000);
    chk("t2_first_valid", first_valid, 1'b0);
    chk("t2_cnt", dut.gen_ch[2].u_counter.cnt_q, 16'd3);
    tvalid = '0;
    tick();

    // Test 3: ch5 and ch1 trip together.
    tvalid = 10'h022;
    repeat (3) tick();
    chk("t3_block_pre", block, 10'h000);
    tick();
    chk("t3_block", block, 10'h022);
    chk("t3_first_ch", first_ch, 4'd1);
    chk("t3_sticky", sticky, 10'h022);
    chk("t3_pulse", trip_pulse, 1'b1);
    tvalid = '0;
    tick();
    chk("t3_block_fall", block, 10'h000);
    chk("t3_state", dut.state_q, StTripped);

    // Test 5: clear on the edge ch7 trips, from TRIPPED.
    tvalid = 10'h080;
    repeat (3) tick();
    chk("t5_pulse_pre", trip_pulse, 1'b0);
    chk("t5_first_ch_pre", first_ch, 4'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_state", dut.state_q, StTripped);
    chk("t5_first_ch", first_ch, 4'd7);
    chk("t5_first_valid", first_valid, 1'b1);
    chk("t5_sticky", sticky, 10'h080);
    chk("t5_pulse", trip_pulse, 1'b1);
    tvalid = '0;

    // Test 6: inst_idle, then enable=0, during long stalls.
    inst_idle = 1'b1;
    tvalid    = 10'h3FF;
    repeat (100) tick();
    chk("t6_idle_block", block, 10'h000);
    chk("t6_idle_cnt", dut.gen_ch[0].u_counter.cnt_q, 16'd0);
    chk("t6_idle_first_ch", first_ch, 4'd7);
    chk("t6_idle_pulse", trip_pulse, 1'b0);
    inst_idle = 1'b0;
    enable    = 1'b0;
    repeat (100) tick();
    chk("t6_dis_block", block, 10'h000);
    chk("t6_dis_state", dut.state_q, StIdle);
    chk("t6_dis_cnt", dut.gen_ch[5].u_counter.cnt_q, 16'd0);
    chk("t6_dis_first_valid", first_valid, 1'b1);
    chk("t6_dis_sticky", sticky, 10'h080);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_idle_clr_valid", first_valid, 1'b0);
    chk("t6_idle_clr_ch", first_ch, 4'd0);
    chk("t6_idle_clr_sticky", sticky, 10'h000);
    enable = 1'b1;
    repeat (4) tick();
    chk("t6_all_block", block, 10'h3FF);
    chk("t6_all_first_ch", first_ch, 4'd0);
    chk("t6_all_valid", first_valid, 1'b1);
    chk("t6_all_pulse", trip_pulse, 1'b1);
    chk("t6_all_sticky", sticky, 10'h3FF);

    // Asynchronous reset mid-stall.
    #3;
    reset = 1'b1;
    #1;
    chk("ar_block", block, 10'h000);
    chk("ar_first_valid", first_valid, 1'b0);
    chk("ar_sticky", sticky, 10'h000);
    chk("ar_pulse", trip_pulse, 1'b0);
    chk("ar_cnt", dut.gen_ch[0].u_counter.cnt_q, 16'd0);
    chk("ar_state", dut.state_q, StIdle);
    #2;
    reset = 1'b0;
    tick();
    chk("ar_restart_cnt", dut.gen_ch[0].u_counter.cnt_q, 16'd1);
    chk("ar_restart_block", block, 10'h000);
    chk("ar_restart_state", dut.state_q, StArmed);
    repeat (3) tick();
    chk("ar_retrip_block", block, 10'h3FF);
    chk("ar_retrip_pulse", trip_pulse, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
